// File: rtl/npc_branch_unit_if.sv
// Bundle between the D-stage decode/comparator logic and the next-PC / branch unit.
// The master side drives the D-stage instruction and flags; the slave side returns fetch and link state.
interface npc_branch_unit_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic [31:0]      D_PC;
  logic [15:0]      D_imm16;
  logic [25:0]      D_imm26;
  logic [31:0]      D_rs;
  logic [3:0]       br_type;
  logic             Zero;
  logic             GreaterZero;
  logic             LessZero;
  logic             check;

  logic [31:0]      F_PC;
  logic             taken;
  logic             E_link_we;
  logic [31:0]      E_link_addr;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output en, D_PC, D_imm16, D_imm26, D_rs, br_type,
           Zero, GreaterZero, LessZero, check,
    input  F_PC, taken, E_link_we, E_link_addr, taken_cnt
  );

  modport slave (
    input  en, D_PC, D_imm16, D_imm26, D_rs, br_type,
           Zero, GreaterZero, LessZero, check,
    output F_PC, taken, E_link_we, E_link_addr, taken_cnt
  );
endinterface

// File: rtl/npc_branch_unit.sv
// Fetch PC register and D-stage branch/jump resolution with one delay slot.
// Also registers the $31 link request into E and keeps a saturating taken-redirect counter.
module npc_branch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  npc_branch_unit_if.slave   bus
);

  typedef enum logic [3:0] {
    BR_NONE  = 4'd0,
    BR_BEQ   = 4'd1,
    BR_BNE   = 4'd2,
    BR_BGTZ  = 4'd3,
    BR_BLTZ  = 4'd4,
    BR_BLEZ  = 4'd5,
    BR_BIOAL = 4'd6,
    BR_J     = 4'd7,
    BR_JAL   = 4'd8,
    BR_JR    = 4'd9
  } br_type_e;

  logic [31:0]      f_pc_q, f_pc_d;
  logic             link_we_q, link_we_d;
  logic [31:0]      link_addr_q, link_addr_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             taken;
  logic [31:0]      target;
  logic [31:0]      branch_tgt;
  logic [31:0]      jump_tgt;
  logic [31:0]      next_pc;
  logic             link_req;

  always_comb begin
    branch_tgt = bus.D_PC + 32'd4 + {{14{bus.D_imm16[15]}}, bus.D_imm16, 2'b00};
    jump_tgt   = {bus.D_PC[31:28], bus.D_imm26, 2'b00};
    taken      = 1'b0;
    target     = branch_tgt;
    link_req   = 1'b0;
    case (bus.br_type)
      BR_BEQ:   taken = bus.Zero;
      BR_BNE:   taken = ~bus.Zero;
      BR_BGTZ:  taken = bus.GreaterZero;
      BR_BLTZ:  taken = bus.LessZero;
      BR_BLEZ:  taken = ~bus.GreaterZero;
      BR_BIOAL: begin
        taken    = bus.check;
        link_req = bus.check;
      end
      BR_J: begin
        taken  = 1'b1;
        target = jump_tgt;
      end
      BR_JAL: begin
        taken    = 1'b1;
        target   = jump_tgt;
        link_req = 1'b1;
      end
      BR_JR: begin
        taken  = 1'b1;
        target = bus.D_rs;
      end
      default: taken = 1'b0;
    endcase
    next_pc = taken ? target : (f_pc_q + 32'd4);
  end

  // A stall holds fetch and the counter, and pushes an empty slot into E.
  always_comb begin
    f_pc_d      = f_pc_q;
    link_we_d   = 1'b0;
    link_addr_d = 32'd0;
    taken_cnt_d = taken_cnt_q;
    if (bus.en) begin
      f_pc_d      = next_pc;
      link_we_d   = link_req;
      link_addr_d = bus.D_PC + 32'd8;
      if (taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
        taken_cnt_d = taken_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q      <= PC_RESET;
      link_we_q   <= 1'b0;
      link_addr_q <= 32'd0;
      taken_cnt_q <= '0;
    end else begin
      f_pc_q      <= f_pc_d;
      link_we_q   <= link_we_d;
      link_addr_q <= link_addr_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign bus.F_PC        = f_pc_q;
  assign bus.taken       = taken;
  assign bus.E_link_we   = link_we_q;
  assign bus.E_link_addr = link_addr_q;
  assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_npc_branch_unit.sv
// Directed bench for npc_branch_unit: stimulus pushes hand-computed expectations into a
// scoreboard queue and a separate monitor compares them just after each rising edge.
module tb_npc_branch_unit;

  typedef struct packed {
    logic        taken;
    logic [31:0] pc;
    logic        we;
    logic [31:0] addr;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  exp_t  exp_q[$];
  string name_q[$];

  npc_branch_unit_if #(.CNT_W(16)) bus ();

  npc_branch_unit #(
    .PC_RESET (32'h0000_3000),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the expectation describes state after the next rising edge.
  task automatic apply_stimulus(
    input string       nm,
    input logic        en,
    input logic [3:0]  br,
    input logic [31:0] dpc,
    input logic [15:0] imm16,
    input logic [25:0] imm26,
    input logic [31:0] rs,
    input logic [3:0]  flags,
    input logic        e_taken,
    input logic [31:0] e_pc,
    input logic        e_we,
    input logic [31:0] e_addr,
    input logic [15:0] e_cnt
  );
    exp_t e;
    @(negedge clk);
    bus.en          = en;
    bus.br_type     = br;
    bus.D_PC        = dpc;
    bus.D_imm16     = imm16;
    bus.D_imm26     = imm26;
    bus.D_rs        = rs;
    bus.Zero        = flags[3];
    bus.GreaterZero = flags[2];
    bus.LessZero    = flags[1];
    bus.check       = flags[0];
    e.taken = e_taken;
    e.pc    = e_pc;
    e.we    = e_we;
    e.addr  = e_addr;
    e.cnt   = e_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check_output({nm, ".taken"},     {31'd0, bus.taken},     {31'd0, e.taken});
        check_output({nm, ".F_PC"},      bus.F_PC,               e.pc);
        check_output({nm, ".link_we"},   {31'd0, bus.E_link_we}, {31'd0, e.we});
        check_output({nm, ".link_addr"}, bus.E_link_addr,        e.addr);
        check_output({nm, ".cnt"},       {16'd0, bus.taken_cnt}, {16'd0, e.cnt});
      end
    end
  end

  initial begin : watchdog
    #100000;
    n_errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : stimulus
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.en = 1'b0;
    bus.br_type = 4'd0;
    bus.D_PC = 32'd0;
    bus.D_imm16 = 16'd0;
    bus.D_imm26 = 26'd0;
    bus.D_rs = 32'd0;
    bus.Zero = 1'b0;
    bus.GreaterZero = 1'b0;
    bus.LessZero = 1'b0;
    bus.check = 1'b0;
    #1;
    check_output("por.F_PC", bus.F_PC, 32'h0000_3000);
    check_output("por.cnt",  {16'd0, bus.taken_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch up to 0x3010.
    apply_stimulus("seq1", 1, 0, 32'h2FFC, 0, 0, 0, 4'b0000, 0, 32'h3004, 0, 32'h3004, 0);
    apply_stimulus("seq2", 1, 0, 32'h3000, 0, 0, 0, 4'b0000, 0, 32'h3008, 0, 32'h3008, 0);
    apply_stimulus("seq3", 1, 0, 32'h3004, 0, 0, 0, 4'b0000, 0, 32'h300C, 0, 32'h300C, 0);
    apply_stimulus("seq4", 1, 0, 32'h3008, 0, 0, 0, 4'b0000, 0, 32'h3010, 0, 32'h3010, 0);
    wait_drain();

    // Asynchronous reset mid-cycle with a taken jump presented.
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.br_type = 4'd7;
    bus.D_imm26 = 26'h0000123;
    #1;
    check_output("rst.F_PC",      bus.F_PC, 32'h0000_3000);
    check_output("rst.link_we",   {31'd0, bus.E_link_we}, 32'd0);
    check_output("rst.link_addr", bus.E_link_addr, 32'd0);
    check_output("rst.cnt",       {16'd0, bus.taken_cnt}, 32'd0);
    check_output("rst.taken",     {31'd0, bus.taken}, 32'd1);
    @(posedge clk);
    #1;
    check_output("rst_hold.F_PC", bus.F_PC, 32'h0000_3000);
    check_output("rst_hold.cnt",  {16'd0, bus.taken_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.en = 1'b0;
    bus.br_type = 4'd0;

    apply_stimulus("beq_t",    1, 1, 32'h3000, 16'hFFFF, 0, 0, 4'b1000, 1, 32'h3000, 0, 32'h3008, 1);
    apply_stimulus("beq_nt",   1, 1, 32'h3000, 16'hFFFF, 0, 0, 4'b0000, 0, 32'h3004, 0, 32'h3008, 1);
    apply_stimulus("bne_t",    1, 2, 32'h3004, 16'h0010, 0, 0, 4'b0000, 1, 32'h3048, 0, 32'h300C, 2);
    apply_stimulus("bioal_t",  1, 6, 32'h3020, 16'h0004, 0, 0, 4'b0001, 1, 32'h3034, 1, 32'h3028, 3);
    apply_stimulus("bioal_nt", 1, 6, 32'h3020, 16'h0004, 0, 0, 4'b0000, 0, 32'h3038, 0, 32'h3028, 3);
    apply_stimulus("jal",      1, 8, 32'h3040, 0, 26'h0000C10, 0, 4'b0000, 1, 32'h3040, 1, 32'h3048, 4);
    apply_stimulus("jr",       1, 9, 32'h3044, 0, 0, 32'h3100, 4'b0000, 1, 32'h3100, 0, 32'h304C, 5);
    apply_stimulus("bgtz_t",   1, 3, 32'h3100, 16'h0002, 0, 0, 4'b0100, 1, 32'h310C, 0, 32'h3108, 6);
    apply_stimulus("bltz_nt",  1, 4, 32'h3108, 16'h0008, 0, 0, 4'b0100, 0, 32'h3110, 0, 32'h3110, 6);
    apply_stimulus("blez_nt",  1, 5, 32'h310C, 16'h0008, 0, 0, 4'b0100, 0, 32'h3114, 0, 32'h3114, 6);
    apply_stimulus("blez_t",   1, 5, 32'h3110, 16'hFFF0, 0, 0, 4'b0000, 1, 32'h30D4, 0, 32'h3118, 7);
    apply_stimulus("br_inval", 1, 12, 32'h30D0, 16'h0004, 26'h1, 32'h5000, 4'b1111, 0, 32'h30D8, 0, 32'h30D8, 7);

    // jal held in D across a three-cycle stall.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus("jal_stall", 0, 8, 32'h30D4, 0, 26'h0000C10, 0, 4'b0000, 1, 32'h30D8, 0, 32'h0, 7);
    end
    apply_stimulus("jal_go",   1, 8, 32'h30D4, 0, 26'h0000C10, 0, 4'b0000, 1, 32'h3040, 1, 32'h30DC, 8);
    apply_stimulus("bltz_t",   1, 4, 32'h3040, 16'h0000, 0, 0, 4'b0010, 1, 32'h3044, 0, 32'h3048, 9);
    apply_stimulus("beq_stall",0, 1, 32'h3044, 16'h0010, 0, 0, 4'b1000, 1, 32'h3044, 0, 32'h0, 9);
    apply_stimulus("beq_flip", 1, 1, 32'h3044, 16'h0010, 0, 0, 4'b0000, 0, 32'h3048, 0, 32'h304C, 9);
    apply_stimulus("jr_top",   1, 9, 32'h3048, 0, 0, 32'hFFFF_FFFC, 4'b0000, 1, 32'hFFFF_FFFC, 0, 32'h3050, 10);
    apply_stimulus("pc_wrap",  1, 0, 32'h304C, 0, 0, 0, 4'b0000, 0, 32'h0000_0000, 0, 32'h3054, 10);
    wait_drain();

    // Preload the counter at its ceiling, then keep redirecting.
    bus.en = 1'b0;
    bus.br_type = 4'd0;
    force dut.taken_cnt_q = 16'hFFFF;
    #1;
    release dut.taken_cnt_q;
    apply_stimulus("sat_beq",  1, 1, 32'h0, 16'h0000, 0, 0, 4'b1000, 1, 32'h4, 0, 32'h8, 16'hFFFF);
    apply_stimulus("sat_stall",0, 7, 32'h0, 0, 26'h10, 0, 4'b0000, 1, 32'h4, 0, 32'h0, 16'hFFFF);
    apply_stimulus("sat_j",    1, 7, 32'h0, 0, 26'h10, 0, 4'b0000, 1, 32'h40, 0, 32'h8, 16'hFFFF);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_branch_unit.md
Name: npc_branch_unit

Overview:
- Consumer end of the D-stage comparator flags (`Zero`, `GreaterZero`, `LessZero`, `check`) in the five-stage MIPS pipeline.
- Owns the F-stage PC register and resolves D-stage branch and jump instructions, with one delay slot.
- Registers the link request (`jal`, `bioal`) into the E stage.
- Keeps a saturating taken-branch counter for debug.

Parameters:
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `CNT_W`, 16, width of the taken-branch counter.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `en`  in  1  1 = F/D advance; 0 = stall (PC holds, bubble into E)
- `D_PC`  in  32  PC of the instruction in D
- `D_imm16`  in  16  branch offset field
- `D_imm26`  in  26  jump index field
- `D_rs`  in  32  forwarded rs value, used as the `jr` target
- `br_type`  in  4  0 none, 1 beq, 2 bne, 3 bgtz, 4 bltz, 5 blez, 6 bioal, 7 j, 8 jal, 9 jr; 10-15 treated as none
- `Zero`  in  1  comparator: rs == rt
- `GreaterZero`  in  1  comparator: signed rs > 0
- `LessZero`  in  1  comparator: signed rs < 0
- `check`  in  1  comparator: rs+rt signed overflow
- `F_PC`  out  32  current fetch PC (register)
- `taken`  out  1  combinational: D instruction redirects the PC
- `E_link_we`  out  1  registered: E-stage instruction writes $31
- `E_link_addr`  out  32  registered: D_PC+8 captured with the link request
- `taken_cnt`  out  CNT_W  saturating count of taken redirects

Behaviour:
- Reset values (asynchronous, on `reset`=1):
  - `F_PC` = `PC_RESET`
  - `E_link_we` = 0
  - `E_link_addr` = 0
  - `taken_cnt` = 0
- Reset asserted mid-stall or mid-branch discards any pending redirect. The first edge after release fetches from `PC_RESET`.
- Taken conditions (combinational, from the current inputs):
  - beq: `Zero`
  - bne: `!Zero`
  - bgtz: `GreaterZero`
  - bltz: `LessZero`
  - blez: `!GreaterZero`
  - bioal: `check`
  - j, jal, jr: always 1
  - none: 0
- Targets:
  - Branches: `D_PC` + 4 + (sign_ext(`D_imm16`) << 2), 32-bit wrap-around with no trap.
  - j/jal: {`D_PC`[31:28], `D_imm26`, 2'b00}.
  - jr: `D_rs`, used unmodified even when misaligned.
- Next PC: `taken` ? target : `F_PC` + 4, with 32-bit wrap-around (0xFFFF_FFFC + 4 = 0).
- Delay slot: the instruction already in F (`D_PC`+4) always completes. The redirect takes effect on the edge that moves the branch out of D. There is no nullification.
- Clock edge with `en`=1:
  - `F_PC` <= next PC.
  - `E_link_we` <= (br_type==jal) | (br_type==bioal & `check`).
  - `E_link_addr` <= `D_PC` + 8.
  - `taken_cnt` increments if `taken`, saturating at all-ones.
- Clock edge with `en`=0 (stall):
  - `F_PC` holds.
  - `E_link_we` <= 0 (bubble into E).
  - `E_link_addr` <= 0.
  - `taken_cnt` holds, so a stalled branch is never double-counted.
- The branch remains in D during a stall and re-evaluates with the updated forwarded flags. Only the flag values present on the advancing edge count.
- bioal is not-taken when `check`=0: no redirect and no link write. The instruction falls through to `D_PC`+8 through normal sequencing.
- `taken` is purely combinational. It is valid whenever `br_type` is valid, independent of `en`.

Test Plan:
- Reset at PC = 0x0000_3010 -> `F_PC` = 0x0000_3000 immediately, without waiting for a clock edge; `E_link_we` = 0; `taken_cnt` = 0.
- beq, `D_PC` = 0x3000, `D_imm16` = 0xFFFF, `Zero` = 1, `en` = 1 -> `taken` = 1; next `F_PC` = 0x3000; `taken_cnt` = 1. Repeat with `Zero` = 0 -> `F_PC` = old `F_PC` + 4.
- bioal, `D_PC` = 0x3020, `D_imm16` = 0x0004, `check` = 1 -> `F_PC` = 0x3034; `E_link_we` = 1; `E_link_addr` = 0x3028. Same with `check` = 0 -> no redirect; `E_link_we` = 0.
- jal, `D_PC` = 0x3040, `D_imm26` = 0x0000C10 -> `F_PC` = 0x0000_3040; `E_link_addr` = 0x3048. jr, `D_rs` = 0x0000_3100 -> `F_PC` = 0x3100; `E_link_we` = 0.
- jal held with `en` = 0 for 3 cycles, then `en` = 1 -> `F_PC` frozen during the stall; `E_link_we` = 0 for the 3 cycles and 1 after release; `taken_cnt` increments by exactly 1.
- Force `taken_cnt` to 0xFFFF, then issue a taken beq -> stays 0xFFFF. Sequential fetch at `F_PC` = 0xFFFF_FFFC -> wraps to 0x0000_0000.
